// File: rtl/nv_nvdla_sdp_wdma_pkg.sv
// Shared types and parameter-legality helpers for the SDP write-DMA stream engine.
package nv_nvdla_sdp_wdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wdma_state_e;

    function automatic bit atom_bytes_legal(input int ab);
        return (ab >= 8) && (ab <= 64) && ((ab & (ab - 1)) == 0);
    endfunction

    function automatic bit pack_legal(input int p);
        return (p == 1) || (p == 2) || (p == 4);
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_wdma_stream_addr_walk.sv
// Walks the destination cube (x along a line, y over lines, s over surfaces)
// and presents the byte address of the next atom plus end-of-line/last flags.
module nv_nvdla_sdp_wdma_addr_walk #(
    parameter int ATOM_BYTES = 32,
    parameter int ADDR_W     = 64,
    parameter int CNT_W      = 13,
    parameter int STRIDE_W   = 28
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [ADDR_W-1:0]   cfg_base_addr_i,
    input  logic [CNT_W-1:0]    cfg_width_i,
    input  logic [CNT_W-1:0]    cfg_height_i,
    input  logic [CNT_W-1:0]    cfg_surfaces_i,
    input  logic [STRIDE_W-1:0] cfg_line_stride_i,
    input  logic [STRIDE_W-1:0] cfg_surf_stride_i,
    output logic [ADDR_W-1:0]   atom_addr_o,
    output logic                eol_o,
    output logic                last_o
);

    localparam int AB_LG = $clog2(ATOM_BYTES);

    logic [CNT_W-1:0]    width_q, height_q, surfaces_q;
    logic [STRIDE_W-1:0] line_stride_q, surf_stride_q;
    logic [CNT_W-1:0]    x_q, y_q, s_q;
    logic [ADDR_W-1:0]   line_base_q, surf_base_q;
    logic [ADDR_W-1:0]   surf_base_d;
    logic                eoh;

    function automatic logic [ADDR_W-1:0] to_bytes(input logic [STRIDE_W-1:0] stride);
        return ADDR_W'(stride) << AB_LG;
    endfunction

    assign eol_o       = (x_q == width_q);
    assign eoh         = (y_q == height_q);
    assign last_o      = eol_o && eoh && (s_q == surfaces_q);
    assign surf_base_d = surf_base_q + to_bytes(surf_stride_q);
    assign atom_addr_o = line_base_q + (ADDR_W'(x_q) << AB_LG);

    always_ff @(posedge clk) begin
        if (srst) begin
            width_q       <= '0;
            height_q      <= '0;
            surfaces_q    <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
            x_q           <= '0;
            y_q           <= '0;
            s_q           <= '0;
            line_base_q   <= '0;
            surf_base_q   <= '0;
        end else if (load_i) begin
            width_q       <= cfg_width_i;
            height_q      <= cfg_height_i;
            surfaces_q    <= cfg_surfaces_i;
            line_stride_q <= cfg_line_stride_i;
            surf_stride_q <= cfg_surf_stride_i;
            x_q           <= '0;
            y_q           <= '0;
            s_q           <= '0;
            line_base_q   <= cfg_base_addr_i & ~ADDR_W'(ATOM_BYTES - 1);
            surf_base_q   <= cfg_base_addr_i & ~ADDR_W'(ATOM_BYTES - 1);
        end else if (step_i) begin
            if (eol_o) begin
                x_q <= '0;
                if (eoh) begin
                    // a new surface restarts its first line at the new surface base
                    y_q         <= '0;
                    s_q         <= (s_q == surfaces_q) ? '0 : s_q + CNT_W'(1);
                    surf_base_q <= surf_base_d;
                    line_base_q <= surf_base_d;
                end else begin
                    y_q         <= y_q + CNT_W'(1);
                    line_base_q <= line_base_q + to_bytes(line_stride_q);
                end
            end else begin
                x_q <= x_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_wdma_stream.sv
// SDP write-DMA stream engine: packs datapath atoms into DMA write requests,
// tracks outstanding writes and signals completion with done/interrupt pulses.
module nv_nvdla_sdp_wdma_stream
    import nv_nvdla_sdp_wdma_pkg::*;
#(
    parameter int ATOM_BYTES = 32,
    parameter int PACK       = 2,
    parameter int ADDR_W     = 64,
    parameter int CNT_W      = 13,
    parameter int STRIDE_W   = 28,
    parameter int MAX_OUTS   = 128
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic                         op_load,
    input  logic [ADDR_W-1:0]            cfg_base_addr,
    input  logic [CNT_W-1:0]             cfg_width,
    input  logic [CNT_W-1:0]             cfg_height,
    input  logic [CNT_W-1:0]             cfg_surfaces,
    input  logic [STRIDE_W-1:0]          cfg_line_stride,
    input  logic [STRIDE_W-1:0]          cfg_surf_stride,
    input  logic                         cfg_intr_ptr,
    input  logic                         cfg_perf_en,
    input  logic                         dp_valid,
    output logic                         dp_ready,
    input  logic [ATOM_BYTES*8-1:0]      dp_pd,
    output logic                         dma_wr_req_valid,
    input  logic                         dma_wr_req_ready,
    output logic [ADDR_W-1:0]            dma_wr_req_addr,
    output logic [PACK*ATOM_BYTES*8-1:0] dma_wr_req_data,
    output logic [PACK-1:0]              dma_wr_req_mask,
    input  logic                         dma_wr_rsp_complete,
    output logic                         busy,
    output logic                         done,
    output logic                         intr_valid,
    output logic                         intr_ptr,
    output logic [31:0]                  stall_cnt
);

    localparam int DW     = ATOM_BYTES * 8;
    localparam int PCNT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int OUTS_W = $clog2(MAX_OUTS) + 1;

    if (!atom_bytes_legal(ATOM_BYTES) || !pack_legal(PACK)) begin : g_param_check
        $error("nv_nvdla_sdp_wdma_stream: illegal ATOM_BYTES or PACK");
    end

    wdma_state_e         state_q;
    logic [PCNT_W-1:0]   pcnt_q;
    logic                out_vld_q, out_last_q, last_seen_q;
    logic [ADDR_W-1:0]   out_addr_q, start_addr_q;
    logic [PACK*DW-1:0]  out_data_q;
    logic [PACK-1:0]     out_mask_q;
    logic [OUTS_W-1:0]   outs_q, outs_d;
    logic                perf_en_q, cfg_ptr_q;
    logic                done_q, intr_valid_q, intr_ptr_q;
    logic [31:0]         stall_q;

    logic                req_valid, req_hs, accept, load, pack_close;
    logic [ADDR_W-1:0]   walk_addr, close_addr;
    logic                walk_eol, walk_last;
    logic [PACK*DW-1:0]  merged;
    logic [PACK-1:0]     close_mask;

    // dp_ready only opens when the output register is free or draining this cycle
    assign req_valid  = out_vld_q && (outs_q != OUTS_W'(MAX_OUTS));
    assign req_hs     = req_valid && dma_wr_req_ready;
    assign dp_ready   = (state_q == ST_RUN) && !last_seen_q && (!out_vld_q || req_hs);
    assign accept     = dp_valid && dp_ready;
    assign load       = (state_q == ST_IDLE) && op_load;
    assign pack_close = accept && ((pcnt_q == PCNT_W'(PACK - 1)) || walk_eol);
    assign close_addr = (pcnt_q == '0) ? walk_addr : start_addr_q;

    nv_nvdla_sdp_wdma_addr_walk #(
        .ATOM_BYTES (ATOM_BYTES),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .STRIDE_W   (STRIDE_W)
    ) u_addr_walk (
        .clk               (nvdla_core_clk),
        .srst              (nvdla_core_rst),
        .load_i            (load),
        .step_i            (accept),
        .cfg_base_addr_i   (cfg_base_addr),
        .cfg_width_i       (cfg_width),
        .cfg_height_i      (cfg_height),
        .cfg_surfaces_i    (cfg_surfaces),
        .cfg_line_stride_i (cfg_line_stride),
        .cfg_surf_stride_i (cfg_surf_stride),
        .atom_addr_o       (walk_addr),
        .eol_o             (walk_eol),
        .last_o            (walk_last)
    );

    // slots are cleared on every close, so unfilled slots of a flushed request read zero
    for (genvar gi = 0; gi < PACK; gi++) begin : g_slot
        logic [DW-1:0] slot_q;

        assign merged[gi*DW +: DW] = (pcnt_q == PCNT_W'(gi)) ? dp_pd : slot_q;
        assign close_mask[gi]      = (PCNT_W'(gi) <= pcnt_q);

        always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst || load || pack_close) begin
                slot_q <= '0;
            end else if (accept && (pcnt_q == PCNT_W'(gi))) begin
                slot_q <= dp_pd;
            end
        end
    end

    always_comb begin
        outs_d = outs_q;
        if (req_hs && !dma_wr_rsp_complete) begin
            outs_d = outs_q + OUTS_W'(1);
        end else if (!req_hs && dma_wr_rsp_complete && (outs_q != '0)) begin
            outs_d = outs_q - OUTS_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            last_seen_q  <= 1'b0;
            out_addr_q   <= '0;
            start_addr_q <= '0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            outs_q       <= '0;
            perf_en_q    <= 1'b0;
            cfg_ptr_q    <= 1'b0;
            done_q       <= 1'b0;
            intr_valid_q <= 1'b0;
            intr_ptr_q   <= 1'b0;
            stall_q      <= '0;
        end else begin
            done_q       <= 1'b0;
            intr_valid_q <= 1'b0;
            if ((state_q != ST_IDLE) && perf_en_q && req_valid && !dma_wr_req_ready &&
                (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (op_load) begin
                        state_q     <= ST_RUN;
                        pcnt_q      <= '0;
                        out_vld_q   <= 1'b0;
                        out_last_q  <= 1'b0;
                        last_seen_q <= 1'b0;
                        outs_q      <= '0;
                        stall_q     <= '0;
                        perf_en_q   <= cfg_perf_en;
                        cfg_ptr_q   <= cfg_intr_ptr;
                    end
                end
                ST_RUN: begin
                    outs_q <= outs_d;
                    if (accept) begin
                        if (pcnt_q == '0) begin
                            start_addr_q <= walk_addr;
                        end
                        pcnt_q <= pack_close ? '0 : pcnt_q + PCNT_W'(1);
                        if (walk_last) begin
                            last_seen_q <= 1'b1;
                        end
                    end
                    if (pack_close) begin
                        out_vld_q  <= 1'b1;
                        out_addr_q <= close_addr;
                        out_data_q <= merged;
                        out_mask_q <= close_mask;
                        out_last_q <= walk_last;
                    end else if (req_hs) begin
                        out_vld_q <= 1'b0;
                    end
                    // final request accepted: finish now if nothing is left outstanding
                    if (req_hs && out_last_q) begin
                        if (outs_d == '0) begin
                            done_q       <= 1'b1;
                            intr_valid_q <= 1'b1;
                            intr_ptr_q   <= cfg_ptr_q;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    outs_q <= outs_d;
                    if (outs_d == '0) begin
                        done_q       <= 1'b1;
                        intr_valid_q <= 1'b1;
                        intr_ptr_q   <= cfg_ptr_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dma_wr_req_valid = req_valid;
    assign dma_wr_req_addr  = out_addr_q;
    assign dma_wr_req_data  = out_data_q;
    assign dma_wr_req_mask  = out_mask_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign intr_valid       = intr_valid_q;
    assign intr_ptr         = intr_ptr_q;
    assign stall_cnt        = stall_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_stream.sv
// Randomized bench for the write-DMA stream engine; expected requests come from
// walking the cube with plain loops, handshake flow from a cycle-level model.
module tb_nv_nvdla_sdp_wdma_stream;

    localparam int AB   = 32;
    localparam int PACK = 2;
    localparam int AW   = 64;
    localparam int CW   = 13;
    localparam int SW   = 28;
    localparam int MO   = 4;
    localparam int DW   = AB * 8;
    localparam int RW   = PACK * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            op_load;
    logic [AW-1:0]   cfg_base_addr;
    logic [CW-1:0]   cfg_width, cfg_height, cfg_surfaces;
    logic [SW-1:0]   cfg_line_stride, cfg_surf_stride;
    logic            cfg_intr_ptr, cfg_perf_en;
    logic            dp_valid, dp_ready;
    logic [DW-1:0]   dp_pd;
    logic            req_valid, req_ready;
    logic [AW-1:0]   req_addr;
    logic [RW-1:0]   req_data;
    logic [PACK-1:0] req_mask;
    logic            rsp_complete;
    logic            busy, done, intr_valid, intr_ptr;
    logic [31:0]     stall_cnt;

    always #5 clk = ~clk;

    nv_nvdla_sdp_wdma_stream #(
        .ATOM_BYTES (AB), .PACK (PACK), .ADDR_W (AW), .CNT_W (CW),
        .STRIDE_W (SW), .MAX_OUTS (MO)
    ) dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rst      (rst),
        .op_load             (op_load),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_width           (cfg_width),
        .cfg_height          (cfg_height),
        .cfg_surfaces        (cfg_surfaces),
        .cfg_line_stride     (cfg_line_stride),
        .cfg_surf_stride     (cfg_surf_stride),
        .cfg_intr_ptr        (cfg_intr_ptr),
        .cfg_perf_en         (cfg_perf_en),
        .dp_valid            (dp_valid),
        .dp_ready            (dp_ready),
        .dp_pd               (dp_pd),
        .dma_wr_req_valid    (req_valid),
        .dma_wr_req_ready    (req_ready),
        .dma_wr_req_addr     (req_addr),
        .dma_wr_req_data     (req_data),
        .dma_wr_req_mask     (req_mask),
        .dma_wr_rsp_complete (rsp_complete),
        .busy                (busy),
        .done                (done),
        .intr_valid          (intr_valid),
        .intr_ptr            (intr_ptr),
        .stall_cnt           (stall_cnt)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [PACK-1:0] mask;
        logic [RW-1:0]   data;
    } req_t;

    req_t          exp_q[$];
    bit            close_q[$];
    logic [DW-1:0] atoms[$];

    int checks = 0;
    int errors = 0;

    // model state
    bit  m_running, m_last_acc, m_done, m_perf, m_ptr;
    int  m_k, m_pending, m_outs, m_hs_cnt, m_nreq;
    int unsigned m_stall;

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_atom();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic build_model(input logic [AW-1:0] base, input int w, input int h, input int s,
                               input logic [SW-1:0] ls, input logic [SW-1:0] ss);
        logic [AW-1:0] abase;
        req_t          r;
        int            pc;
        bit            cl;
        logic [DW-1:0] a;
        exp_q.delete();
        close_q.delete();
        atoms.delete();
        abase  = base & ~64'(AB - 1);
        pc     = 0;
        r.addr = '0;
        r.mask = '0;
        r.data = '0;
        for (int si = 0; si <= s; si++)
            for (int yi = 0; yi <= h; yi++)
                for (int x = 0; x <= w; x++) begin
                    a = rand_atom();
                    atoms.push_back(a);
                    if (pc == 0) begin
                        r.addr = abase + (64'(si) * 64'(ss) + 64'(yi) * 64'(ls) + 64'(x)) * 64'(AB);
                        r.data = '0;
                    end
                    r.data[pc*DW +: DW] = a;
                    cl = (pc == PACK - 1) || (x == w);
                    close_q.push_back(cl);
                    if (cl) begin
                        r.mask = PACK'((1 << (pc + 1)) - 1);
                        exp_q.push_back(r);
                        pc = 0;
                    end else begin
                        pc++;
                    end
                end
        m_nreq = exp_q.size();
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int w, input int h, input int s,
                           input logic [SW-1:0] ls, input logic [SW-1:0] ss,
                           input bit ptr, input bit perf, input int dp_pct, input int rdy_pct,
                           input int cmp_pct, input bit bp_mode, input int abort_at);
        bit finished, after_rst, exp_valid, exp_dp_ready, acc, hs, cmp;
        int cyc, bp_left;
        build_model(base, w, h, s, ls, ss);
        finished  = 0;
        after_rst = 0;
        cyc       = 0;
        bp_left   = 5;
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            exp_valid = (m_pending > 0) && (m_outs != MO);
            rst = (abort_at > 0) && (cyc == abort_at);
            if (cyc == 0) begin
                op_load         = 1'b1;
                cfg_base_addr   = base;
                cfg_width       = CW'(w);
                cfg_height      = CW'(h);
                cfg_surfaces    = CW'(s);
                cfg_line_stride = ls;
                cfg_surf_stride = ss;
                cfg_intr_ptr    = ptr;
                cfg_perf_en     = perf;
            end else begin
                // stray loads carry junk config that must not be picked up
                op_load         = m_running && ($urandom_range(15) == 0);
                cfg_base_addr   = {$urandom, $urandom};
                cfg_width       = CW'($urandom);
                cfg_height      = CW'($urandom);
                cfg_surfaces    = CW'($urandom);
                cfg_line_stride = SW'($urandom);
                cfg_surf_stride = SW'($urandom);
                cfg_intr_ptr    = 1'($urandom);
                cfg_perf_en     = 1'($urandom);
            end
            dp_valid = m_running && (m_k < atoms.size()) && ($urandom_range(99) < dp_pct);
            dp_pd    = dp_valid ? atoms[m_k] : rand_atom();
            if (bp_mode) req_ready = (bp_left == 0);
            else         req_ready = ($urandom_range(99) < rdy_pct);
            rsp_complete = ((m_outs > 0) && ($urandom_range(99) < cmp_pct)) || ($urandom_range(31) == 0);
            #1;
            exp_dp_ready = m_running && !m_last_acc && ((m_pending == 0) || (exp_valid && req_ready));
            check_val("dp_ready", dp_ready, exp_dp_ready);
            check_val("req_valid", req_valid, exp_valid);
            check_val("busy", busy, m_running);
            check_val("done", done, m_done);
            check_val("intr_valid", intr_valid, m_done);
            check_val("stall_cnt", stall_cnt, m_stall);
            if (m_done) check_val("intr_ptr", intr_ptr, m_ptr);
            if (exp_valid) begin
                check_val("req_addr", req_addr, exp_q[0].addr);
                check_val("req_mask", req_mask, exp_q[0].mask);
                check_val("req_data", req_data, exp_q[0].data);
            end
            if (after_rst) begin
                check_val("rst_addr", req_addr, '0);
                check_val("rst_mask", req_mask, '0);
                check_val("rst_data", req_data, '0);
                check_val("rst_intr_ptr", intr_ptr, '0);
                finished = 1;
            end
            if (m_done) finished = 1;
            $display("cyc %0d acc=%0b hs=%0b cmp=%0b outs=%0d", cyc,
                     dp_valid && exp_dp_ready, exp_valid && req_ready, rsp_complete, m_outs);

            acc = dp_valid && exp_dp_ready;
            hs  = exp_valid && req_ready;
            cmp = rsp_complete;
            if (bp_mode && exp_valid && bp_left > 0) bp_left--;
            if (rst) begin
                m_running = 0; m_pending = 0; m_outs = 0; m_stall = 0;
                m_done = 0; m_last_acc = 0;
                after_rst = 1;
            end else begin
                m_done = 0;
                if (cyc == 0) begin
                    m_running = 1; m_k = 0; m_pending = 0; m_outs = 0; m_hs_cnt = 0;
                    m_stall = 0; m_last_acc = 0; m_perf = perf; m_ptr = ptr;
                end else if (m_running) begin
                    if (m_perf && exp_valid && !req_ready) m_stall++;
                    if (acc) begin
                        if (close_q[m_k]) m_pending++;
                        if (m_k == atoms.size() - 1) m_last_acc = 1;
                        m_k++;
                    end
                    if (hs) begin
                        m_pending--;
                        m_hs_cnt++;
                        void'(exp_q.pop_front());
                    end
                    if (hs && !cmp)                     m_outs++;
                    else if (!hs && cmp && m_outs > 0)  m_outs--;
                    if (m_hs_cnt == m_nreq && m_outs == 0) begin
                        m_done    = 1;
                        m_running = 0;
                    end
                end
            end
            cyc++;
        end
        check_val("job_finished", finished, 1'b1);
        rst          = 1'b0;
        op_load      = 1'b0;
        dp_valid     = 1'b0;
        rsp_complete = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_load = 1'b0; cfg_base_addr = '0; cfg_width = '0; cfg_height = '0;
        cfg_surfaces = '0; cfg_line_stride = '0; cfg_surf_stride = '0; cfg_intr_ptr = 1'b0;
        cfg_perf_en = 1'b0; dp_valid = 1'b0; dp_pd = '0; req_ready = 1'b0; rsp_complete = 1'b0;
        m_running = 0; m_last_acc = 0; m_done = 0; m_perf = 0; m_ptr = 0;
        m_k = 0; m_pending = 0; m_outs = 0; m_hs_cnt = 0; m_nreq = 0; m_stall = 0;
        repeat (3) @(negedge clk);
        req_ready = 1'b1;
        #1;
        check_val("reset_dp_ready", dp_ready, '0);
        check_val("reset_req_valid", req_valid, '0);
        check_val("reset_req_addr", req_addr, '0);
        check_val("reset_req_data", req_data, '0);
        check_val("reset_req_mask", req_mask, '0);
        check_val("reset_busy", busy, '0);
        check_val("reset_done", done, '0);
        check_val("reset_intr", {intr_valid, intr_ptr}, '0);
        check_val("reset_stall", stall_cnt, '0);
        rst = 1'b0;

        // full packs, end-of-line flush, line/surface strides
        run_job(64'h1000, 3, 0, 0, 28'h0, 28'h0, 1'b1, 1'b0, 100, 100, 100, 1'b0, 0);
        run_job(64'h1000, 2, 0, 0, 28'h0, 28'h0, 1'b0, 1'b0, 100, 100, 100, 1'b0, 0);
        run_job(64'h1000, 1, 1, 1, 28'h10, 28'h40, 1'b1, 1'b0, 100, 100, 100, 1'b0, 0);
        // backpressure with the stall counter enabled
        run_job(64'h1000, 3, 0, 0, 28'h0, 28'h0, 1'b0, 1'b1, 100, 100, 100, 1'b1, 0);
        check_val("bp_stall_cnt", stall_cnt, 32'd5);
        // outstanding limit with slow completes
        run_job(64'h2000, 15, 0, 0, 28'h0, 28'h0, 1'b1, 1'b1, 100, 100, 8, 1'b0, 0);
        // reset in the middle of a run, then a clean run afterwards
        run_job(64'h3000, 7, 3, 0, 28'h8, 28'h0, 1'b1, 1'b1, 100, 60, 50, 1'b0, 6);
        run_job(64'h3000, 4, 1, 1, 28'h8, 28'h20, 1'b1, 1'b1, 80, 70, 50, 1'b0, 0);
        for (int j = 0; j < 20; j++) begin
            run_job({$urandom, $urandom}, $urandom_range(5), $urandom_range(2), $urandom_range(2),
                    SW'($urandom), SW'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(90, 10), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
